du: RTL and testbench
=====================

DU -- requirements
Module: DU

Interface
REQ-001 Parameter Q, default 26, number of fractional bits of every data port (Q5.26 format).
REQ-002 Parameter W, default 32, width of every data port.
REQ-003 clk  input  1  clock; all registers update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 valid_in  input  1  F and s_xi are valid this cycle.
REQ-006 F  input  W signed  numerator, Q5.26.
REQ-007 s_xi  input  W signed  denominator offset, Q5.26; the divisor is 1 + s_xi.
REQ-008 valid_out  output  1  one-cycle pulse marking a new result.
REQ-009 exponent  output  W signed  log2(|F| / (1 + s_xi)), Q5.26, Mitchell approximation.
REQ-010 result_sign  output  1  sign of the quotient; 1 = negative.

Function
REQ-011 The DU SHALL be fully pipelined, accept one input per cycle, and have no stalls or backpressure.
REQ-012 Stage 0 SHALL register the following: |F| as unsigned W-bit, sign = F[W-1], and denominator_stage0 = s_xi + 2^Q (0x04000000).
REQ-013 The denominator sum SHALL be formed in W+1 bits and saturated to 0x7FFFFFFF on positive overflow.
REQ-014 Stage 1 SHALL find the leading-one position p of |F| and of the denominator.
REQ-015 Stage 2 SHALL normalize each operand so the bits below its leading one fill a Q-bit fraction field, left-aligned; it SHALL zero-fill when p < Q and truncate when p > Q.
REQ-016 Stage 3 SHALL register the following for verification visibility: s1_stage3 = p(|F|) - Q, s2_stage3 = p(den) - Q (signed integers), m1_stage3 and m2_stage3 = normalized fractions in Q-bit units.
REQ-017 Stage 4 SHALL register exponent = ((s1 - s2) << Q) + (m1 - m2), computed with W-bit two's-complement arithmetic.
REQ-018 Stage 4 SHALL register result_sign = sign of F.
REQ-019 Latency: an input sampled at rising edge k SHALL drive valid_out high for exactly the cycle following edge k+4, with its result on exponent and result_sign.
REQ-020 The valid bit SHALL travel with the data through every stage; back-to-back inputs SHALL give back-to-back valid_out pulses.
REQ-021 exponent and result_sign SHALL update only when a valid result reaches stage 4, and SHALL otherwise hold their last value.
REQ-022 F = 0: exponent SHALL be 0x80000000 and result_sign SHALL be 0.
REQ-023 Denominator <= 0 (s_xi <= -1.0): exponent SHALL be 0x7FFFFFFF, with result_sign per REQ-018.
REQ-024 F = 0x80000000: |F| SHALL be treated as 2^(W-1) unsigned.
REQ-025 Division SHALL be realised only as log-domain subtraction; no divider or multiplier SHALL be used.

Reset
REQ-026 While rst_n = 0, every pipeline register, valid bit, valid_out, exponent and result_sign SHALL be 0, regardless of clk.
REQ-027 Asserting reset mid-operation SHALL discard every in-flight input; no valid_out SHALL appear for those inputs after release.
REQ-028 The first input sampled after release SHALL be processed normally with the REQ-019 latency.

Verification
REQ-029 F = 0x1C000000 (7.0), s_xi = 0x08000000 (2.0) -> exponent 0x05000000 (1.25, 2^e = 2.378), result_sign 0, valid_out pulse 5 cycles after input.
REQ-030 F = 0x2C000000 (11.0), s_xi = 0x18000000 (6.0) -> denominator_stage0 0x1C000000, exponent 0x02800000 (0.625).
REQ-031 F = 0x34000000 (13.0), s_xi = 0x10000000 (4.0) -> exponent 0x05800000 (1.375); F = 0x20000000 (8.0), s_xi = 0 -> denominator_stage0 0x04000000, exponent 0x0C000000 (3.0).
REQ-032 F = 0xBC000000 (-17.0), s_xi = 0x0C000000 (3.0) -> exponent 0x08400000 (2.0625), result_sign 1.
REQ-033 F = 0, s_xi = 0x04000000 -> exponent 0x80000000, result_sign 0; s_xi = 0xFC000000 (-1.0), F = 1.0 -> exponent 0x7FFFFFFF.
REQ-034 Five back-to-back valid inputs with reset asserted after the third -> no valid_out for any of them; outputs read 0 until a new input completes.

Source files
------------

// File: rtl/du.sv
// du: pipelined Mitchell log-domain divider, exponent = log2(|F| / (1 + s_xi)) in Q5.26.
module du #(
    parameter int Q = 26,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic signed [W-1:0] F,
    input  logic signed [W-1:0] s_xi,
    output logic                valid_out,
    output logic signed [W-1:0] exponent,
    output logic                result_sign
);
    localparam int PW = $clog2(W);
    localparam logic [PW-1:0] QP = PW'(Q);
    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};

    function automatic logic [PW-1:0] lead(input logic [W-1:0] x);
        lead = '0;
        for (int i = 0; i < W; i++)
            if (x[i]) lead = PW'(i);
    endfunction

    // bits below the leading one, left-aligned into a Q-bit fraction
    function automatic logic [Q-1:0] norm(input logic [W-1:0] x, input logic [PW-1:0] p);
        norm = Q'(p < QP ? x << (QP - p) : x >> (p - QP));
    endfunction

    logic [W:0]   den_sum;
    logic         v0, v1, v2, v3;
    logic [W-1:0] abs_f0, denominator_stage0, x1, d1;
    logic         sign0, sign1, sign2, sign3;
    logic [PW-1:0] p1, q1, p2, q2;
    logic         zf1, zf2, zf3, db1, db2, db3;
    logic [Q-1:0] m1_2, m2_2, m1_stage3, m2_stage3;
    logic signed [W-1:0] s1_stage3, s2_stage3;

    assign den_sum = {s_xi[W-1], s_xi} + (W+1)'(1 << Q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v0, v1, v2, v3, valid_out} <= '0;
            {abs_f0, denominator_stage0, x1, d1} <= '0;
            {sign0, sign1, sign2, sign3, result_sign} <= '0;
            {p1, q1, p2, q2} <= '0;
            {zf1, zf2, zf3, db1, db2, db3} <= '0;
            {m1_2, m2_2, m1_stage3, m2_stage3} <= '0;
            {s1_stage3, s2_stage3, exponent} <= '0;
        end else begin
            v0 <= valid_in;
            abs_f0 <= F[W-1] ? W'(-F) : F;
            sign0 <= F[W-1];
            denominator_stage0 <= den_sum[W:W-1] == 2'b01 ? POS_MAX : den_sum[W-1:0];
            v1 <= v0;
            x1 <= abs_f0;
            d1 <= denominator_stage0;
            p1 <= lead(abs_f0);
            q1 <= lead(denominator_stage0);
            sign1 <= sign0;
            zf1 <= abs_f0 == '0;
            db1 <= denominator_stage0[W-1] || denominator_stage0 == '0;
            v2 <= v1;
            p2 <= p1;
            q2 <= q1;
            m1_2 <= norm(x1, p1);
            m2_2 <= norm(d1, q1);
            {sign2, zf2, db2} <= {sign1, zf1, db1};
            v3 <= v2;
            s1_stage3 <= W'(p2) - W'(Q);
            s2_stage3 <= W'(q2) - W'(Q);
            m1_stage3 <= m1_2;
            m2_stage3 <= m2_2;
            {sign3, zf3, db3} <= {sign2, zf2, db2};
            valid_out <= v3;
            if (v3) begin
                exponent <= zf3 ? NEG_MAX : db3 ? POS_MAX :
                            ((s1_stage3 - s2_stage3) << Q) + (W'(m1_stage3) - W'(m2_stage3));
                result_sign <= zf3 ? 1'b0 : sign3;
            end
        end
    end
endmodule

// File: tb/tb_du.sv
// tb_du: random and directed checks of du against an arithmetic log2 model.
module tb_du;
    logic clk = 0, rst_n = 0, valid_in = 0, valid_out, result_sign;
    logic [31:0] f = 0, s_xi = 0;
    logic signed [31:0] exponent;
    int total = 0, bad = 0, cyc = 0;
    typedef struct {int due; logic [31:0] e; logic sg;} exp_t;
    exp_t q[$];
    logic [31:0] last_e = 0;
    logic last_s = 0;

    du dut (.clk(clk), .rst_n(rst_n), .valid_in(valid_in), .F(f), .s_xi(s_xi),
            .valid_out(valid_out), .exponent(exponent), .result_sign(result_sign));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int lg(input longint x);
        int e = 0;
        while ((x >> (e + 1)) != 0) e++;
        return e;
    endfunction

    function automatic longint fr(input longint x, input int e);
        longint y = x - (64'sh1 <<< e);
        return e >= 26 ? y >>> (e - 26) : y <<< (26 - e);
    endfunction

    function automatic logic [31:0] mdl(input logic [31:0] ff, input logic [31:0] ss);
        longint a, d, r;
        int e1, e2;
        a = ff[31] ? 64'sh1_0000_0000 - longint'(ff) : longint'(ff);
        d = longint'($signed(ss)) + 64'sh400_0000;
        if (d > 64'sh7FFF_FFFF) d = 64'sh7FFF_FFFF;
        if (a == 0) return 32'h8000_0000;
        if (d <= 0) return 32'h7FFF_FFFF;
        e1 = lg(a);
        e2 = lg(d);
        r = (longint'(e1 - e2) <<< 26) + fr(a, e1) - fr(d, e2);
        return r[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("valid", 32'(valid_out), 32'd1);
            chk("exp", exponent, q[0].e);
            chk("sign", 32'(result_sign), 32'(q[0].sg));
            last_e = q[0].e;
            last_s = q[0].sg;
            void'(q.pop_front());
        end else begin
            chk("novalid", 32'(valid_out), 32'd0);
            chk("hold_exp", exponent, last_e);
            chk("hold_sign", 32'(result_sign), 32'(last_s));
        end
    endtask

    task automatic send(input logic v, input logic [31:0] ff, input logic [31:0] ss,
                        input logic [31:0] ee, input logic sg);
        valid_in = v;
        f = ff;
        s_xi = ss;
        if (v) q.push_back('{cyc + 5, ee, sg});
        step();
    endtask

    task automatic sendm(input logic [31:0] ff, input logic [31:0] ss);
        send(1'b1, ff, ss, mdl(ff, ss), ff[31]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, $urandom, $urandom, 32'd0, 1'b0);
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_exp", exponent, 32'd0);
        chk("rst_sign", 32'(result_sign), 32'd0);
        idle(3);
        rst_n = 1;
        send(1'b1, 32'h1C00_0000, 32'h0800_0000, 32'h0500_0000, 1'b0);
        idle(6);
        send(1'b1, 32'h2C00_0000, 32'h1800_0000, 32'h0280_0000, 1'b0);
        send(1'b1, 32'h3400_0000, 32'h1000_0000, 32'h0580_0000, 1'b0);
        send(1'b1, 32'h2000_0000, 32'h0000_0000, 32'h0C00_0000, 1'b0);
        send(1'b1, 32'hBC00_0000, 32'h0C00_0000, 32'h0840_0000, 1'b1);
        send(1'b1, 32'h0000_0000, 32'h0400_0000, 32'h8000_0000, 1'b0);
        send(1'b1, 32'h0400_0000, 32'hFC00_0000, 32'h7FFF_FFFF, 1'b0);
        send(1'b1, 32'hFC00_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        send(1'b1, 32'h8000_0000, 32'h0000_0000, 32'h1400_0000, 1'b1);
        send(1'b1, 32'h0400_0000, 32'h7FFF_FFFF, 32'hEC00_0001, 1'b0);
        sendm(32'h0000_0001, 32'h0000_0000);
        idle(6);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ff, ss;
            ff = $urandom >> $urandom_range(0, 31);
            ss = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) ff = -ff;
            if ($urandom_range(0, 2) == 0) ss = -ss;
            if ($urandom_range(0, 3) != 0) sendm(ff, ss);
            else idle(1);
        end
        idle(6);
        for (int i = 0; i < 3; i++) sendm($urandom, $urandom >> 4);
        rst_n = 0;
        #1;
        q.delete();
        last_e = 0;
        last_s = 0;
        chk("midrst_valid", 32'(valid_out), 32'd0);
        chk("midrst_exp", exponent, 32'd0);
        chk("midrst_sign", 32'(result_sign), 32'd0);
        valid_in = 1;
        f = 32'h9000_0000;
        s_xi = 32'h0100_0000;
        step();
        step();
        rst_n = 1;
        idle(8);
        sendm(32'h1C00_0000, 32'h0800_0000);
        idle(6);
        if (q.size() != 0) chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
